// File: rtl/seq_detector_param.sv
// Serial N-bit pattern detector with a run-time loadable pattern, overlap control and a saturating match counter.
// Optional build macro SEQDET_MASK_EN adds a per-bit don't-care mask that is loaded alongside the pattern.
module seq_detector_param #(
  parameter int             N           = 5,
  parameter logic [N-1:0]   DEFAULT_PAT = 5'b10110,
  parameter int             CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
`ifdef SEQDET_MASK_EN
  input  logic [N-1:0]     pat_mask_in,
`endif
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FW      = $clog2(N+1);
  localparam logic [FW-1:0]    FULL    = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N-1:0]     r_hist;
  logic [FW-1:0]    r_fill;
  logic [N-1:0]     r_pat;
  logic [CNT_W-1:0] r_cnt;

  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_hist_nxt;
  logic [FW-1:0]    w_fill_nxt;
  logic             w_match;
  logic             w_detect;

`ifdef SEQDET_MASK_EN
  logic [N-1:0] r_mask;
  assign w_mask = r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_mask <= {N{1'b1}};
    else if (pat_load) r_mask <= pat_mask_in;
  end
`else
  assign w_mask = {N{1'b1}};
`endif

  assign w_match = (r_fill == FULL) && (((r_hist ^ r_pat) & w_mask) == '0);

  // Non-overlap: the bit following a hit opens a fresh window of length 1.
  always_comb begin
    w_hist_nxt = {r_hist[N-2:0], din};
    w_fill_nxt = r_fill;
    if (w_match && !overlap)  w_fill_nxt = FW'(1);
    else if (r_fill != FULL)  w_fill_nxt = r_fill + FW'(1);
  end

  // Event is judged on next-state values so it lines up with match rising for a new window.
  assign w_detect = en && !pat_load && (w_fill_nxt == FULL) &&
                    (((w_hist_nxt ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEFAULT_PAT;
    end else if (pat_load) begin
      r_pat  <= pat_in;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_cnt <= '0;
    else if (cnt_clr)                   r_cnt <= '0;
    else if (w_detect && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign match     = w_match;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default N=5 instance plus an N=2/CNT_W=2 instance for saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, din, overlap, pat_load, cnt_clr;
  logic [4:0] pat_in;
  logic       match;
  logic [7:0] match_cnt;

  logic       en2, din2, cnt_clr2;
  logic [1:0] pat_in2;
  logic       match2;
  logic [1:0] match_cnt2;

`ifdef SEQDET_MASK_EN
  logic [4:0] pat_mask_in  = 5'b11111;
  logic [1:0] pat_mask_in2 = 2'b11;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt)
  );

  seq_detector_param #(.N(2), .DEFAULT_PAT(2'b11), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .din(din2), .overlap(1'b1),
    .pat_load(1'b0), .pat_in(pat_in2),
`ifdef SEQDET_MASK_EN
    .pat_mask_in(pat_mask_in2),
`endif
    .cnt_clr(cnt_clr2), .match(match2), .match_cnt(match_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one enabled bit and settle just after the sampling edge.
  task automatic send(input logic b);
    en = 1'b1; din = b;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rst();
    rst = 1'b1; #3; rst = 1'b0; #1;
  endtask

  initial begin
    rst = 1'b1; en = 0; din = 0; overlap = 1; pat_load = 0; cnt_clr = 0; pat_in = '0;
    en2 = 0; din2 = 0; cnt_clr2 = 0; pat_in2 = '0;
    #12;
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic detection 1,0,1,1,0.
    send(1); send(0); send(1); send(1);
    chk("basic_b4_match", match, 0);
    send(0);
    chk("basic_b5_match", match, 1);
    chk("basic_cnt", match_cnt, 1);

    // Overlapping stream 1,0,1,1,0,1,1,0.
    pulse_rst(); overlap = 1;
    send(1); send(0); send(1); send(1); send(0);
    chk("ovl_b5_match", match, 1);
    send(1);
    chk("ovl_b6_match", match, 0);
    send(1); send(0);
    chk("ovl_b8_match", match, 1);
    chk("ovl_cnt", match_cnt, 2);

    // Same stream, non-overlapping.
    pulse_rst(); overlap = 0;
    send(1); send(0); send(1); send(1); send(0);
    chk("novl_b5_match", match, 1);
    send(1); send(1); send(0);
    chk("novl_b8_match", match, 0);
    chk("novl_cnt", match_cnt, 1);

    // Hold with en=0 keeps match high and count steady.
    pulse_rst(); overlap = 1;
    send(1); send(0); send(1); send(1); send(0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("hold_match", match, 1);
    end
    chk("hold_cnt", match_cnt, 1);
    send(0);
    chk("hold_release_match", match, 0);

    // Pattern load with en=1 on the same edge: din ignored, window restarts.
    pat_load = 1; pat_in = 5'b11100; en = 1; din = 1;
    @(posedge clk); #1;
    pat_load = 0; en = 0;
    chk("load_match", match, 0);
    send(1); send(1); send(1); send(0);
    chk("load_b4_match", match, 0);
    send(0);
    chk("load_b5_match", match, 1);
    chk("load_cnt", match_cnt, 2);
    send(1); send(0); send(1); send(1); send(0);
    chk("oldpat_match", match, 0);
    chk("oldpat_cnt", match_cnt, 2);

    // Saturation on the N=2 / CNT_W=2 instance, din held 1.
    en2 = 1; din2 = 1;
    @(posedge clk); #1;
    chk("sat_first_match", match2, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("sat_cnt", match_cnt2, 3);
    chk("sat_match", match2, 1);
    cnt_clr2 = 1;
    @(posedge clk); #1;
    cnt_clr2 = 0;
    chk("clr_wins_cnt", match_cnt2, 0);
    @(posedge clk); #1;
    en2 = 0;
    chk("post_clr_cnt", match_cnt2, 1);

    // Async reset mid-pattern after a loaded pattern has matched.
    pat_load = 1; pat_in = 5'b11100;
    @(posedge clk); #1;
    pat_load = 0;
    send(1); send(1); send(1); send(0); send(0);
    chk("pre_rst_match", match, 1);
    send(1); send(1); send(1);
    chk("pre_rst_cnt", match_cnt, 3);
    #2 rst = 1'b1; #1;
    chk("async_rst_match", match, 0);
    chk("async_rst_cnt", match_cnt, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(1); send(0); send(1); send(1);
    chk("after_rst_b4_match", match, 0);
    send(0);
    chk("after_rst_defpat_match", match, 1);
    chk("after_rst_cnt", match_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
